// File: rtl/muldiv_pkg.sv
// Shared types and operation-class helpers for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

  // RV32M funct3 encodings
  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } op_e;

  // Controller states: IDLE waits for issue, CALC iterates one bit per cycle,
  // DONE is the single write-back cycle.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  // Division and remainder share the restoring-divide path.
  function automatic logic is_div(op_e op);
    return (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
  endfunction

  // Remainder ops return the high half of the divide accumulator.
  function automatic logic is_rem(op_e op);
    return (op == OP_REM) || (op == OP_REMU);
  endfunction

  // Operand A is two's complement for MUL, MULH, MULHSU, DIV and REM.
  function automatic logic is_signed_a(op_e op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
           (op == OP_DIV) || (op == OP_REM);
  endfunction

  // Operand B is two's complement for MUL, MULH, DIV and REM (MULHSU keeps B unsigned).
  function automatic logic is_signed_b(op_e op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide execute unit.
// Magnitudes are processed by a shared 2*XLEN shift register and one adder/subtractor
// (shift-add for multiply, restoring shift-subtract for divide); signs are restored in
// the cycle that enters DONE. Divide-by-zero and signed overflow skip the iteration.
//
// Handshake: an issue is accepted on a rising edge where start=1, flush=0 and busy=0;
// start during busy is dropped, never queued, so the issuer holds start until busy=0.
// wb_en is a one-cycle pulse in DONE (suppressed for rd=0, flush or reset in that
// cycle); wb_rd/wb_data are registered on entry to DONE and hold until the next DONE.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int AWIDTH = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              flush,
  input  logic [2:0]        funct3,
  input  logic [XLEN-1:0]   rs1_val,
  input  logic [XLEN-1:0]   rs2_val,
  input  logic [AWIDTH-1:0] rd_in,
  output logic              busy,
  output logic              wb_en,
  output logic [AWIDTH-1:0] wb_rd,
  output logic [XLEN-1:0]   wb_data,
  output state_e            dbg_state
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CW-1:0]   LAST_CNT = CW'(XLEN - 1);

  state_e              state_q, state_d;
  op_e                 op_q, op_d;
  logic [AWIDTH-1:0]   rd_q, rd_d;
  logic                neg_q, neg_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [XLEN-1:0]     b_q, b_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [AWIDTH-1:0]   wb_rd_q, wb_rd_d;
  logic [XLEN-1:0]     wb_data_q, wb_data_d;

  // Issue-side decode
  op_e                 op_in;
  logic                sign_a, sign_b, neg_in;
  logic [XLEN-1:0]     abs_a, abs_b;
  logic                div_zero, div_ovf, special;
  logic [XLEN-1:0]     special_res;

  // Iteration datapath
  logic                div_mode;
  logic [XLEN:0]       add_x, add_y;
  logic [XLEN+1:0]     sum;
  logic                ge;
  logic [2*XLEN-1:0]   acc_step;
  logic [2*XLEN-1:0]   prod_fix;
  logic [XLEN-1:0]     div_pick, div_fix, calc_res;

  // Decode the incoming op: operand magnitudes, result sign and bypass cases
  always_comb begin
    op_in       = op_e'(funct3);
    sign_a      = is_signed_a(op_in) & rs1_val[XLEN-1];
    sign_b      = is_signed_b(op_in) & rs2_val[XLEN-1];
    abs_a       = sign_a ? ('0 - rs1_val) : rs1_val;
    abs_b       = sign_b ? ('0 - rs2_val) : rs2_val;
    neg_in      = is_rem(op_in) ? sign_a : (sign_a ^ sign_b);
    div_zero    = is_div(op_in) && (rs2_val == '0);
    div_ovf     = ((op_in == OP_DIV) || (op_in == OP_REM)) &&
                  (rs1_val == MIN_INT) && (rs2_val == '1);
    special     = div_zero || div_ovf;
    special_res = '0;
    if (div_zero) begin
      special_res = is_rem(op_in) ? rs1_val : '1;
    end else if (div_ovf) begin
      special_res = is_rem(op_in) ? '0 : MIN_INT;
    end
  end

  // One iteration step through the shared adder, plus sign fix-up of the final step
  always_comb begin
    div_mode = is_div(op_q);
    if (div_mode) begin
      add_x = acc_q[2*XLEN-1:XLEN-1];
      add_y = ~{1'b0, b_q};
    end else begin
      add_x = {1'b0, acc_q[2*XLEN-1:XLEN]};
      add_y = acc_q[0] ? {1'b0, b_q} : '0;
    end
    // For divide the carry-in completes the two's complement of B; carry-out means no borrow
    sum = {1'b0, add_x} + {1'b0, add_y} + {{(XLEN+1){1'b0}}, div_mode};
    ge  = sum[XLEN+1];
    if (div_mode) begin
      acc_step = {(ge ? sum[XLEN-1:0] : acc_q[2*XLEN-2:XLEN-1]), acc_q[XLEN-2:0], ge};
    end else begin
      acc_step = {sum[XLEN:0], acc_q[XLEN-1:1]};
    end
    prod_fix = neg_q ? ('0 - acc_step) : acc_step;
    div_pick = is_rem(op_q) ? acc_step[2*XLEN-1:XLEN] : acc_step[XLEN-1:0];
    div_fix  = neg_q ? ('0 - div_pick) : div_pick;
    if (div_mode) begin
      calc_res = div_fix;
    end else if (op_q == OP_MUL) begin
      calc_res = prod_fix[XLEN-1:0];
    end else begin
      calc_res = prod_fix[2*XLEN-1:XLEN];
    end
  end

  // Next-state and register updates for the controller and datapath
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    rd_d      = rd_q;
    neg_d     = neg_q;
    acc_d     = acc_q;
    b_d       = b_q;
    cnt_d     = cnt_q;
    wb_rd_d   = wb_rd_q;
    wb_data_d = wb_data_q;
    unique case (state_q)
      IDLE: begin
        if (start && !flush) begin
          op_d  = op_in;
          rd_d  = rd_in;
          neg_d = neg_in;
          acc_d = {{XLEN{1'b0}}, abs_a};
          b_d   = abs_b;
          cnt_d = '0;
          if (special) begin
            state_d   = DONE;
            wb_rd_d   = rd_in;
            wb_data_d = special_res;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          acc_d = acc_step;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_CNT) begin
            state_d   = DONE;
            wb_rd_d   = rd_q;
            wb_data_d = calc_res;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      op_q      <= OP_MUL;
      rd_q      <= '0;
      neg_q     <= 1'b0;
      acc_q     <= '0;
      b_q       <= '0;
      cnt_q     <= '0;
      wb_rd_q   <= '0;
      wb_data_q <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      rd_q      <= rd_d;
      neg_q     <= neg_d;
      acc_q     <= acc_d;
      b_q       <= b_d;
      cnt_q     <= cnt_d;
      wb_rd_q   <= wb_rd_d;
      wb_data_q <= wb_data_d;
    end
  end

  // Outputs: write pulse is killed by flush/reset arriving in the DONE cycle
  always_comb begin
    busy      = (state_q != IDLE);
    wb_en     = (state_q == DONE) && (rd_q != '0) && !flush && !reset;
    wb_rd     = wb_rd_q;
    wb_data   = wb_data_q;
    dbg_state = state_q;
  end

endmodule
